msi_cache_ctrl: RTL and testbench
=================================

# msi_cache_ctrl

Per-CPU snooping cache controller. It sits directly downstream of a CPU request stage and consumes its `writeOut`/`readOut`/`tagOut`/`dataOut` outputs. It holds a small direct-mapped cache with per-line MSI state, and serves CPU reads and writes locally when possible. It arbitrates for the shared bus to issue read-miss, write-miss, invalidate and writeback transactions, and snoops transactions issued by the other CPUs.

## Interface
- `LINES`, 4, number of cache lines (power of 2); index = `tag[log2(LINES)-1:0]`, full 12-bit tag stored per line
- `clock` in 1: the only clock; all state changes on its rising edge
- `reset` in 1: synchronous, active-high
- `cpu_write` in 1, `cpu_read` in 1: CPU request, level-held; write wins if both high
- `cpu_tag` in 12, `cpu_data` in 16: request address and write data
- `cpu_done` out 1: one-cycle completion pulse
- `cpu_rdata` out 16: read result, valid while `cpu_done`=1
- `cpu_busy` out 1: high in every state except IDLE
- `bus_req` out 1, `bus_gnt` in 1: bus arbitration
- `bus_cmd` out 2: 00 none, 01 read miss, 10 write miss, 11 invalidate
- `bus_tag` out 12: address of the issued command
- `bus_wb` out 1, `bus_wdata` out 16: writeback strobe and data
- `mem_valid` in 1, `mem_rdata` in 16: fill data return
- `snoop_valid` in 1, `snoop_cmd` in 2, `snoop_tag` in 12: other CPUs' bus traffic
- `snoop_hit` out 1, `snoop_data` out 16: this cache supplies a Modified line

## Operation
- FSM states: IDLE, LOOKUP, BUS_REQ, ISSUE, WRITEBACK, FILL, DONE, RELEASE.
- IDLE: when `cpu_write|cpu_read`, capture op/tag/data and go to LOOKUP.
- LOOKUP: reads the line combinationally.
  - Read hit (S/M) -> DONE.
  - Write hit M -> write data -> DONE.
  - Write hit S -> BUS_REQ, pending cmd invalidate.
  - Miss with victim M -> BUS_REQ, pending writeback, then miss.
  - Miss otherwise -> BUS_REQ, pending read/write miss.
  - If `snoop_valid` targets the same index this cycle, stay in LOOKUP one extra cycle.
- BUS_REQ: `bus_req`=1. On `bus_gnt`=1, re-evaluate the pending cmd, then go to ISSUE, or to WRITEBACK if a writeback is pending. A pending invalidate whose line is no longer valid with a matching tag becomes a write miss.
- WRITEBACK: `bus_wb`=1 with victim tag/data for one cycle. The victim goes to I, then return to BUS_REQ for the miss.
- ISSUE: `bus_cmd`/`bus_tag` driven one cycle.
  - Invalidate: line goes to M, data written -> DONE.
  - Miss -> FILL.
- FILL: wait for `mem_valid`, then install the line.
  - Read: state S, data = `mem_rdata`.
  - Write: state M, data = `cpu_data`.
  - Then -> DONE.
- DONE: `cpu_done`=1 and `cpu_rdata`=line data -> RELEASE.
- RELEASE: wait until `cpu_write`=`cpu_read`=0 -> IDLE. The requester must idle at least one cycle between requests; a held request never re-executes.
- Snoop runs every cycle in parallel with the FSM, and only on a valid line with a matching tag:
  - Read miss: M -> S, with `snoop_hit`=1 and `snoop_data`=line.
  - Write miss: M -> I with data supplied; S -> I.
  - Invalidate: S/M -> I.
  - No match, or `snoop_cmd`=00: no change, `snoop_hit`=0.
- A snoop update and an FSM update to the same line in the same cycle: the FSM update wins; snoop outputs still reflect the pre-edge state.

## Timing
- Reset values: all lines I with tag 0 and data 0; FSM in IDLE; every output 0.
- Reset mid-transaction aborts the transaction; `bus_req` is 0 the cycle after reset is sampled.
- All outputs are registered or Moore-decoded; none depends combinationally on the inputs.
- Hit: request first high in cycle N -> LOOKUP in N+1 -> `cpu_done` in N+2.
- Bus transaction: grant sampled in cycle G -> ISSUE or WRITEBACK in G+1.
- Fill: `mem_valid` in cycle F -> `cpu_done` in F+1.
- Snoop: `snoop_hit`/`snoop_data` are valid the cycle after `snoop_valid`, and last one cycle.
- `bus_req` stays high until the grant is sampled. `bus_gnt` is ignored outside BUS_REQ.

## Configuration
- `MSI_PERF_COUNT_EN` defined: adds output ports `hit_count` out 16 and `miss_count` out 16.
  - Each increments once per LOOKUP resolution; a write-hit-S counts as a miss.
  - Both wrap 0xFFFF -> 0 and reset to 0.
- `MSI_PERF_COUNT_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Cold read: read tag 0x005, grant, `mem_rdata`=0xBEEF -> `bus_cmd`=01, `bus_tag`=0x005, `cpu_rdata`=0xBEEF, line 1 in state S.
- Write hit S: write 0x005 data 0x1234 -> `bus_cmd`=11, line goes to M. Then read 0x005 -> `cpu_done` two cycles after the request with 0x1234 and no `bus_req`.
- Eviction: with 0x005 in M, write 0x009 -> `bus_wb`=1 with tag 0x005 data 0x1234, then `bus_cmd`=10 with tag 0x009; line 1 ends as M, tag 0x009.
- Snoop supply: line in M with 0x009; snoop read miss 0x009 -> next cycle `snoop_hit`=1, `snoop_data`=line, state S. A following snoop invalidate -> I.
- Race: pending invalidate waiting in BUS_REQ, then snoop write miss on the same tag, then grant -> `bus_cmd`=10, not 11, followed by FILL.
- Reset in FILL, plus a held request: reset asserted -> all outputs 0 and lines I. A request held high after DONE does not retrigger until it drops for at least one cycle.

Source files
------------

// File: rtl/msi_cache_ctrl.sv
// msi_cache_ctrl: per-CPU snooping cache controller with a direct-mapped,
// MSI-coherent line store.
//
// Ports:
//   clock, reset           - single clock, synchronous active-high reset
//   cpu_write/read/tag/data - level-held CPU request (write wins)
//   cpu_done/rdata/busy    - completion pulse, read data, busy status
//   bus_req/gnt            - shared-bus arbitration
//   bus_cmd/tag            - issued command (01 rd miss, 10 wr miss, 11 inv)
//   bus_wb/wdata           - victim writeback strobe and data
//   mem_valid/rdata        - fill data return
//   snoop_valid/cmd/tag    - other CPUs' bus traffic
//   snoop_hit/data         - this cache supplies a Modified line
// Optional feature macro: MSI_PERF_COUNT_EN adds hit_count / miss_count.
module msi_cache_ctrl #(
    parameter int unsigned LINES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_write,
    input  logic        cpu_read,
    input  logic [11:0] cpu_tag,
    input  logic [15:0] cpu_data,
    output logic        cpu_done,
    output logic [15:0] cpu_rdata,
    output logic        cpu_busy,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [1:0]  bus_cmd,
    output logic [11:0] bus_tag,
    output logic        bus_wb,
    output logic [15:0] bus_wdata,
    input  logic        mem_valid,
    input  logic [15:0] mem_rdata,
    input  logic        snoop_valid,
    input  logic [1:0]  snoop_cmd,
    input  logic [11:0] snoop_tag,
    output logic        snoop_hit,
    output logic [15:0] snoop_data
`ifdef MSI_PERF_COUNT_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int unsigned TAG_W  = 12;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned IDX_W  = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOOKUP    = 3'd1;
    localparam logic [2:0] S_BUS_REQ   = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_FILL      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;
    localparam logic [2:0] S_RELEASE   = 3'd7;

    localparam logic [1:0] CMD_NONE    = 2'b00;
    localparam logic [1:0] CMD_RD_MISS = 2'b01;
    localparam logic [1:0] CMD_WR_MISS = 2'b10;
    localparam logic [1:0] CMD_INV     = 2'b11;

    localparam logic [1:0] L_I = 2'd0;
    localparam logic [1:0] L_S = 2'd1;
    localparam logic [1:0] L_M = 2'd2;

    // line store
    logic [1:0]        r_line_st   [LINES];
    logic [TAG_W-1:0]  r_line_tag  [LINES];
    logic [DATA_W-1:0] r_line_data [LINES];

    // FSM and captured request
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_is_write;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_cmd;
    logic [1:0]        w_cmd_nxt;
    logic              r_wb_pend;
    logic              w_wb_nxt;
    logic              w_capture;

    // FSM line write port
    logic              w_line_we;
    logic [1:0]        w_line_st_nxt;
    logic [TAG_W-1:0]  w_line_tag_nxt;
    logic [DATA_W-1:0] w_line_data_nxt;

    logic              r_snoop_hit;
    logic [DATA_W-1:0] r_snoop_data;

    // current request's line
    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_line_st;
    logic [TAG_W-1:0]  w_line_tag;
    logic [DATA_W-1:0] w_line_data;
    logic              w_line_hit;

    // snooped line
    logic [IDX_W-1:0]  w_snp_idx;
    logic [1:0]        w_snp_st;
    logic [DATA_W-1:0] w_snp_data;
    logic              w_snp_match;
    logic              w_snp_same_idx;

    assign w_idx       = r_tag[IDX_W-1:0];
    assign w_line_st   = r_line_st[w_idx];
    assign w_line_tag  = r_line_tag[w_idx];
    assign w_line_data = r_line_data[w_idx];
    assign w_line_hit  = (w_line_st != L_I) && (w_line_tag == r_tag);

    assign w_snp_idx      = snoop_tag[IDX_W-1:0];
    assign w_snp_st       = r_line_st[w_snp_idx];
    assign w_snp_data     = r_line_data[w_snp_idx];
    assign w_snp_match    = snoop_valid && (w_snp_st != L_I) &&
                            (r_line_tag[w_snp_idx] == snoop_tag);
    // a snoop to the line under lookup settles first; lookup retries next cycle
    assign w_snp_same_idx = snoop_valid && (w_snp_idx == w_idx);

    // next-state and FSM line update
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_wb_nxt        = r_wb_pend;
        w_capture       = 1'b0;
        w_line_we       = 1'b0;
        w_line_st_nxt   = w_line_st;
        w_line_tag_nxt  = w_line_tag;
        w_line_data_nxt = w_line_data;

        case (r_state)
            S_IDLE: begin
                if (cpu_write || cpu_read) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!w_snp_same_idx) begin
                    if (w_line_hit && !r_is_write) begin
                        w_state_nxt = S_DONE;
                    end else if (w_line_hit && (w_line_st == L_M)) begin
                        w_line_we       = 1'b1;
                        w_line_data_nxt = r_wdata;
                        w_state_nxt     = S_DONE;
                    end else if (w_line_hit) begin
                        w_cmd_nxt   = CMD_INV;
                        w_wb_nxt    = 1'b0;
                        w_state_nxt = S_BUS_REQ;
                    end else begin
                        w_cmd_nxt   = r_is_write ? CMD_WR_MISS : CMD_RD_MISS;
                        w_wb_nxt    = (w_line_st == L_M);
                        w_state_nxt = S_BUS_REQ;
                    end
                end
            end
            S_BUS_REQ: begin
                if (bus_gnt) begin
                    // a victim snooped out of M no longer needs writing back
                    if (r_wb_pend && (w_line_st == L_M)) begin
                        w_state_nxt = S_WRITEBACK;
                    end else begin
                        w_wb_nxt = 1'b0;
                        if ((r_cmd == CMD_INV) && !w_line_hit) begin
                            w_cmd_nxt = CMD_WR_MISS;
                        end
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_WRITEBACK: begin
                w_line_we     = 1'b1;
                w_line_st_nxt = L_I;
                w_wb_nxt      = 1'b0;
                w_state_nxt   = S_BUS_REQ;
            end
            S_ISSUE: begin
                if (r_cmd == CMD_INV) begin
                    w_line_we       = 1'b1;
                    w_line_st_nxt   = L_M;
                    w_line_data_nxt = r_wdata;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_valid) begin
                    w_line_we       = 1'b1;
                    w_line_tag_nxt  = r_tag;
                    w_line_st_nxt   = r_is_write ? L_M : L_S;
                    w_line_data_nxt = r_is_write ? r_wdata : mem_rdata;
                    w_state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!cpu_write && !cpu_read) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // state, request capture, snoop and line store
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_is_write   <= 1'b0;
            r_tag        <= '0;
            r_wdata      <= '0;
            r_cmd        <= CMD_NONE;
            r_wb_pend    <= 1'b0;
            r_snoop_hit  <= 1'b0;
            r_snoop_data <= '0;
            for (int unsigned i = 0; i < LINES; i++) begin
                r_line_st[IDX_W'(i)]   <= L_I;
                r_line_tag[IDX_W'(i)]  <= '0;
                r_line_data[IDX_W'(i)] <= '0;
            end
        end else begin
            r_state   <= w_state_nxt;
            r_cmd     <= w_cmd_nxt;
            r_wb_pend <= w_wb_nxt;
            if (w_capture) begin
                r_is_write <= cpu_write;
                r_tag      <= cpu_tag;
                r_wdata    <= cpu_data;
            end

            r_snoop_hit  <= 1'b0;
            r_snoop_data <= '0;
            if (w_snp_match) begin
                case (snoop_cmd)
                    CMD_RD_MISS: begin
                        if (w_snp_st == L_M) begin
                            r_line_st[w_snp_idx] <= L_S;
                            r_snoop_hit          <= 1'b1;
                            r_snoop_data         <= w_snp_data;
                        end
                    end
                    CMD_WR_MISS: begin
                        if (w_snp_st == L_M) begin
                            r_snoop_hit  <= 1'b1;
                            r_snoop_data <= w_snp_data;
                        end
                        r_line_st[w_snp_idx] <= L_I;
                    end
                    CMD_INV: begin
                        r_line_st[w_snp_idx] <= L_I;
                    end
                    default: begin
                    end
                endcase
            end

            // placed after the snoop so the FSM update wins on a collision
            if (w_line_we) begin
                r_line_st[w_idx]   <= w_line_st_nxt;
                r_line_tag[w_idx]  <= w_line_tag_nxt;
                r_line_data[w_idx] <= w_line_data_nxt;
            end
        end
    end

`ifdef MSI_PERF_COUNT_EN
    logic        w_lookup_done;
    logic        w_local_hit;
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    assign w_lookup_done = (r_state == S_LOOKUP) && !w_snp_same_idx;
    assign w_local_hit   = w_line_hit && (!r_is_write || (w_line_st == L_M));

    // one count per resolved lookup; write-hit-S counts as a miss
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (w_lookup_done) begin
            if (w_local_hit) begin
                r_hit_count <= r_hit_count + 16'd1;
            end else begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

    // Moore-decoded outputs
    assign cpu_busy   = (r_state != S_IDLE);
    assign cpu_done   = (r_state == S_DONE);
    assign cpu_rdata  = (r_state == S_DONE) ? w_line_data : '0;
    assign bus_req    = (r_state == S_BUS_REQ);
    assign bus_cmd    = (r_state == S_ISSUE) ? r_cmd : CMD_NONE;
    assign bus_tag    = (r_state == S_ISSUE)     ? r_tag :
                        (r_state == S_WRITEBACK) ? w_line_tag : '0;
    assign bus_wb     = (r_state == S_WRITEBACK);
    assign bus_wdata  = (r_state == S_WRITEBACK) ? w_line_data : '0;
    assign snoop_hit  = r_snoop_hit;
    assign snoop_data = r_snoop_data;

endmodule

// File: tb/tb_msi_cache_ctrl.sv
// tb_msi_cache_ctrl: scoreboard bench for msi_cache_ctrl. The driver plays
// CPU, bus arbiter and memory; a line-level MSI model pushes the expected
// responses, and a monitor pops them as the DUT presents them.
module tb_msi_cache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_write, cpu_read;
    logic [11:0] cpu_tag;
    logic [15:0] cpu_data;
    logic        cpu_done;
    logic [15:0] cpu_rdata;
    logic        cpu_busy;
    logic        bus_req, bus_gnt;
    logic [1:0]  bus_cmd;
    logic [11:0] bus_tag;
    logic        bus_wb;
    logic [15:0] bus_wdata;
    logic        mem_valid;
    logic [15:0] mem_rdata;
    logic        snoop_valid;
    logic [1:0]  snoop_cmd;
    logic [11:0] snoop_tag;
    logic        snoop_hit;
    logic [15:0] snoop_data;
`ifdef MSI_PERF_COUNT_EN
    logic [15:0] hit_count, miss_count;
`endif

    always #5 clock = ~clock;

    msi_cache_ctrl #(.LINES(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_write(cpu_write), .cpu_read(cpu_read),
        .cpu_tag(cpu_tag), .cpu_data(cpu_data),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_cmd(bus_cmd), .bus_tag(bus_tag),
        .bus_wb(bus_wb), .bus_wdata(bus_wdata),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_tag(snoop_tag),
        .snoop_hit(snoop_hit), .snoop_data(snoop_data)
`ifdef MSI_PERF_COUNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        wb;
        logic [1:0]  cmd;
        logic [11:0] tag;
        logic [15:0] data;
    } bus_ev_t;

    bus_ev_t     exp_bus[$];
    logic [15:0] exp_done[$];
    logic [15:0] exp_snp[$];

    // reference model: 0=I 1=S 2=M per line
    int          m_st[4];
    logic [11:0] m_tag[4];
    logic [15:0] m_data[4];
    int          m_hits;
    int          m_misses;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_tag[i] = 12'h0; m_data[i] = 16'h0;
        end
        m_hits = 0; m_misses = 0;
    endtask

    task automatic check_quiet(input string nm);
        chk({nm, "_ctl"}, {28'h0, cpu_done, cpu_busy, bus_req, bus_wb}, 32'h0);
        chk({nm, "_bus"}, {2'b00, bus_cmd, bus_tag, bus_wdata}, 32'h0);
        chk({nm, "_dat"}, {cpu_rdata, snoop_data}, 32'h0);
        chk({nm, "_snp"}, {31'h0, snoop_hit}, 32'h0);
    endtask

    // monitor: pop and compare whenever the DUT presents a response
    always @(negedge clock) begin
        if (!reset) begin
            if (cpu_done) begin
                if (exp_done.size() == 0) begin
                    total++; bad++;
                    $display("FAIL done_unexpected act=%0h exp=none", cpu_rdata);
                end else begin
                    logic [15:0] e;
                    e = exp_done.pop_front();
                    chk("cpu_rdata", {16'h0, cpu_rdata}, {16'h0, e});
                end
            end
            if (bus_wb || (bus_cmd != 2'b00)) begin
                if (exp_bus.size() == 0) begin
                    total++; bad++;
                    $display("FAIL bus_unexpected act=wb%0b cmd%0h tag%0h exp=none", bus_wb, bus_cmd, bus_tag);
                end else begin
                    bus_ev_t e;
                    e = exp_bus.pop_front();
                    chk("bus_wb", {31'h0, bus_wb}, {31'h0, e.wb});
                    chk("bus_cmd", {30'h0, bus_cmd}, {30'h0, e.cmd});
                    chk("bus_tag", {20'h0, bus_tag}, {20'h0, e.tag});
                    if (e.wb) chk("bus_wdata", {16'h0, bus_wdata}, {16'h0, e.data});
                end
            end
            if (snoop_hit) begin
                if (exp_snp.size() == 0) begin
                    total++; bad++;
                    $display("FAIL snoop_unexpected act=%0h exp=none", snoop_data);
                end else begin
                    logic [15:0] e;
                    e = exp_snp.pop_front();
                    chk("snoop_data", {16'h0, snoop_data}, {16'h0, e});
                end
            end
        end
    end

    // one CPU request; called and returns at a falling edge
    task automatic do_req(input bit wr, input logic [11:0] tag, input logic [15:0] data,
                          input logic [15:0] mdata, input bit race, input bit abort,
                          input bit hold);
        int      idx;
        bit      hit, local_hit, done, granted, mem_sent, saw_req, race_done, abort_arm;
        int      n, fill_cnt, k;
        bus_ev_t ev;
        idx = int'(tag[1:0]);
        hit = (m_st[idx] != 0) && (m_tag[idx] == tag);
        local_hit = hit && (!wr || (m_st[idx] == 2));
        if (local_hit) m_hits++; else m_misses++;

        if (hit && !wr) begin
            exp_done.push_back(m_data[idx]);
        end else if (local_hit) begin
            m_data[idx] = data;
            exp_done.push_back(data);
        end else if (hit) begin
            // a write miss from another CPU during arbitration turns the upgrade into a miss
            ev = '{wb: 1'b0, cmd: race ? 2'b10 : 2'b11, tag: tag, data: 16'h0};
            exp_bus.push_back(ev);
            m_st[idx] = 2; m_data[idx] = data;
            exp_done.push_back(data);
        end else begin
            if (m_st[idx] == 2) begin
                ev = '{wb: 1'b1, cmd: 2'b00, tag: m_tag[idx], data: m_data[idx]};
                exp_bus.push_back(ev);
            end
            ev = '{wb: 1'b0, cmd: wr ? 2'b10 : 2'b01, tag: tag, data: 16'h0};
            exp_bus.push_back(ev);
            if (!abort) begin
                m_st[idx] = wr ? 2 : 1; m_tag[idx] = tag;
                m_data[idx] = wr ? data : mdata;
                exp_done.push_back(m_data[idx]);
            end
        end

        cpu_write = wr;
        cpu_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        cpu_tag   = tag;
        cpu_data  = data;
        n = 0; fill_cnt = 0; done = 0; granted = 0; mem_sent = 0;
        saw_req = 0; race_done = 0; abort_arm = 0;
        while (!done && n < 300) begin
            @(negedge clock);
            n++;
            bus_gnt = 1'b0; mem_valid = 1'b0; snoop_valid = 1'b0; snoop_cmd = 2'b00;
            if (granted) chk("grant_lat", {31'h0, (bus_cmd != 2'b00) || bus_wb}, 32'h1);
            granted = 0;
            if (mem_sent) chk("fill_lat", {31'h0, cpu_done}, 32'h1);
            mem_sent = 0;
            if (bus_req) saw_req = 1;
            if (abort_arm) begin
                reset = 1'b1; cpu_write = 1'b0; cpu_read = 1'b0;
                @(negedge clock);
                reset = 1'b0;
                model_reset();
                check_quiet("abort");
                done = 1;
            end else if (cpu_done) begin
                done = 1;
                if (local_hit) begin
                    chk("hit_lat", n, 2);
                    chk("hit_no_req", {31'h0, saw_req}, 32'h0);
                end
            end else begin
                if (fill_cnt > 0) begin
                    fill_cnt--;
                    if (fill_cnt == 0) begin
                        mem_valid = 1'b1; mem_rdata = mdata; mem_sent = 1;
                    end
                end
                if ((bus_cmd == 2'b01) || (bus_cmd == 2'b10)) begin
                    if (abort) abort_arm = 1;
                    else fill_cnt = $urandom_range(1, 3);
                end
                if (bus_req) begin
                    if (race && !race_done) begin
                        snoop_valid = 1'b1; snoop_cmd = 2'b10; snoop_tag = tag;
                        race_done = 1;
                    end else if ($urandom_range(0, 2) == 0) begin
                        bus_gnt = 1'b1; granted = 1;
                    end
                end
            end
        end
        chk("req_done", {31'h0, done}, 32'h1);
        if (abort) return;

        if (hold) begin
            for (int h = 0; h < 3; h++) begin
                @(negedge clock);
                chk("hold_busy", {31'h0, cpu_busy}, 32'h1);
                chk("hold_nodone", {31'h0, cpu_done}, 32'h0);
            end
        end
        cpu_write = 1'b0; cpu_read = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (cpu_busy && k < 10);
        chk("release", {31'h0, cpu_busy}, 32'h0);
    endtask

    task automatic do_snoop(input logic [1:0] cmd, input logic [11:0] tag);
        int idx;
        idx = int'(tag[1:0]);
        if ((cmd != 2'b00) && (m_st[idx] != 0) && (m_tag[idx] == tag)) begin
            case (cmd)
                2'b01: if (m_st[idx] == 2) begin exp_snp.push_back(m_data[idx]); m_st[idx] = 1; end
                2'b10: begin
                    if (m_st[idx] == 2) exp_snp.push_back(m_data[idx]);
                    m_st[idx] = 0;
                end
                default: m_st[idx] = 0;
            endcase
        end
        snoop_valid = 1'b1; snoop_cmd = cmd; snoop_tag = tag;
        @(negedge clock);
        snoop_valid = 1'b0; snoop_cmd = 2'b00;
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1);
    end

    initial begin
        logic [11:0] t;
        reset = 1'b1; cpu_write = 1'b0; cpu_read = 1'b0; cpu_tag = '0; cpu_data = '0;
        bus_gnt = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        snoop_valid = 1'b0; snoop_cmd = '0; snoop_tag = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check_quiet("rst");
        reset = 1'b0;
        @(negedge clock);
        check_quiet("idle");

        do_req(1'b0, 12'h005, 16'h0000, 16'hBEEF, 0, 0, 0);   // cold read
        do_req(1'b1, 12'h005, 16'h1234, 16'h0000, 0, 0, 0);   // write hit S
        do_req(1'b0, 12'h005, 16'h0000, 16'h0000, 0, 0, 0);   // read hit M
        do_req(1'b1, 12'h009, 16'h5678, 16'h0000, 0, 0, 0);   // eviction
        do_snoop(2'b01, 12'h009);                              // supply, M -> S
        do_snoop(2'b11, 12'h009);                              // S -> I
        do_snoop(2'b01, 12'h009);                              // no hit now
        do_req(1'b0, 12'h00D, 16'h0000, 16'h0A0A, 0, 0, 0);
        do_req(1'b1, 12'h00D, 16'h7777, 16'h0000, 1, 0, 0);   // invalidate race
        do_req(1'b0, 12'h00D, 16'h0000, 16'h0000, 0, 0, 1);   // held request
        do_req(1'b0, 12'h012, 16'h0000, 16'h3C3C, 0, 1, 0);   // reset in FILL
        do_req(1'b0, 12'h00D, 16'h0000, 16'h4242, 0, 0, 0);   // lines cleared by reset

        for (int it = 0; it < 60; it++) begin
            t = 12'(($urandom_range(0, 2) << 4) | $urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7)
                do_req(1'($urandom_range(0, 1)), t, 16'($urandom), 16'($urandom), 0, 0,
                       ($urandom_range(0, 3) == 0));
            else
                do_snoop(2'($urandom_range(0, 3)), t);
        end

        repeat (4) @(negedge clock);
        chk("left_done", exp_done.size(), 0);
        chk("left_bus", exp_bus.size(), 0);
        chk("left_snoop", exp_snp.size(), 0);
`ifdef MSI_PERF_COUNT_EN
        chk("hit_count", {16'h0, hit_count}, {16'h0, 16'(m_hits)});
        chk("miss_count", {16'h0, miss_count}, {16'h0, 16'(m_misses)});
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
